// File: rtl/lsu_pkg.sv
// Shared types, constants and lane helpers for the load/store unit.
// Build option LSU_MISALIGN_TRAP_EN (see lsu.sv) traps misaligned accesses.
package lsu_pkg;

  localparam int WSTRB_W = 4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  // Byte enables for a store of the given size at an already size-aligned offset.
  function automatic logic [WSTRB_W-1:0] lsu_wstrb(input logic [1:0] size,
                                                   input logic [1:0] off);
    logic [WSTRB_W-1:0] strb;
    case (size)
      BYTE:    strb = 4'b0001 << off;
      HALF:    strb = 4'b0011 << {off[1], 1'b0};
      WORD:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
    logic mis;
    case (size)
      HALF:    mis = off[0];
      WORD:    mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and strobes, load shift/extract/extend.
// Offset bits below the access size are ignored, so a word always uses lane 0.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]         i_size,
  input  logic [1:0]         i_offset,
  input  logic               i_we,
  input  logic               i_unsigned,
  input  logic [31:0]        i_wdata,
  input  logic [31:0]        i_rdata,
  output logic [WSTRB_W-1:0] o_wstrb,
  output logic [31:0]        o_wdata,
  output logic [31:0]        o_rdata
);

  logic [1:0]  w_off;
  logic [31:0] w_shifted;

  // Size-aligned offset.
  always_comb begin
    w_off = 2'b00;
    case (i_size)
      BYTE:    w_off = i_offset;
      HALF:    w_off = {i_offset[1], 1'b0};
      WORD:    w_off = 2'b00;
      default: w_off = 2'b00;
    endcase
  end

  // Store strobes and lane-replicated write data.
  always_comb begin
    o_wdata = i_wdata;
    if (i_we) begin
      o_wstrb = lsu_wstrb(i_size, w_off);
    end else begin
      o_wstrb = 4'b0000;
    end
    case (i_size)
      BYTE:    o_wdata = {4{i_wdata[7:0]}};
      HALF:    o_wdata = {2{i_wdata[15:0]}};
      WORD:    o_wdata = i_wdata;
      default: o_wdata = i_wdata;
    endcase
  end

  // Load data shift, extract and extend.
  always_comb begin
    w_shifted = i_rdata >> {w_off, 3'b000};
    o_rdata   = 32'h0000_0000;
    case (i_size)
      BYTE: begin
        if (i_unsigned) begin
          o_rdata = {24'h00_0000, w_shifted[7:0]};
        end else begin
          o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
        end
      end
      HALF: begin
        if (i_unsigned) begin
          o_rdata = {16'h0000, w_shifted[15:0]};
        end else begin
          o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
        end
      end
      WORD:    o_rdata = w_shifted;
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory transaction per request with a bounded ready wait.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned requests with an error and no access.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic [WSTRB_W-1:0] mem_wstrb,
  input  logic [31:0]        mem_rdata,
  output logic               busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e         r_state;
  logic [1:0]         r_size;
  logic [1:0]         r_off;
  logic               r_we;
  logic               r_unsigned;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_valid;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [WSTRB_W-1:0] r_mem_wstrb;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;

  logic               w_idle;
  logic               w_req_err;
  logic               w_timeout;
  logic [1:0]         w_al_size;
  logic [1:0]         w_al_off;
  logic [WSTRB_W-1:0] w_wstrb;
  logic [31:0]        w_wdata;
  logic [31:0]        w_rdata;

  assign w_idle    = (r_state == IDLE);
  assign req_ready = w_idle;
  assign busy      = !w_idle;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_req_err = (req_size == 2'b11) || lsu_misaligned(req_size, req_addr[1:0]);
`else
  assign w_req_err = (req_size == 2'b11);
`endif

  // Ready has priority: a handshake in the last allowed cycle is a success.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  // Store lanes come from the live request in IDLE; load lanes from the captured op.
  assign w_al_size = w_idle ? req_size : r_size;
  assign w_al_off  = w_idle ? req_addr[1:0] : r_off;

  lsu_align u_align (
    .i_size     (w_al_size),
    .i_offset   (w_al_off),
    .i_we       (req_we),
    .i_unsigned (r_unsigned),
    .i_wdata    (req_wdata),
    .i_rdata    (mem_rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata)
  );

  // Control FSM with capture registers, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_size      <= 2'b00;
      r_off       <= 2'b00;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_wstrb <= 4'b0000;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_size     <= req_size;
            r_off      <= req_addr[1:0];
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_cnt      <= {CNT_W{1'b0}};
            if (w_req_err) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0000_0000;
            end else begin
              r_state     <= ACCESS;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= {req_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
              r_mem_wstrb <= w_wstrb;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            r_state     <= RESP;
            r_mem_valid <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_we ? 32'h0000_0000 : w_rdata;
          end else if (w_timeout) begin
            r_state     <= RESP;
            r_mem_valid <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'h0000_0000;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'h0000_0000;
        end
        default: begin
          r_state     <= IDLE;
          r_mem_valid <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with TIMEOUT_CYCLES = 4; expectations are hand-computed.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // Full op with ready in cycle 1: accept, handshake, response, back to idle.
  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata);
    drive_req(we, size, uns, addr, wdata);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".mem_valid"}, {31'b0, mem_valid}, 32'h1);
    check({tag, ".req_ready"}, {31'b0, req_ready}, 32'h0);
    check({tag, ".mem_addr"}, mem_addr, exp_addr);
    check({tag, ".mem_wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_strb});
    if (we) check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    mem_ready = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    check({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'h1);
    check({tag, ".rsp_err"}, {31'b0, rsp_err}, 32'h0);
    check({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".mem_valid_off"}, {31'b0, mem_valid}, 32'h0);
    @(negedge clk);
    check({tag, ".rsp_done"}, {31'b0, rsp_valid}, 32'h0);
    check({tag, ".ready_back"}, {31'b0, req_ready}, 32'h1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst.req_ready", {31'b0, req_ready}, 32'h1);
    check("rst.busy", {31'b0, busy}, 32'h0);
    check("rst.mem_valid", {31'b0, mem_valid}, 32'h0);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst.rsp_err", {31'b0, rsp_err}, 32'h0);
    check("rst.rsp_rdata", rsp_rdata, 32'h0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    access("ld_w",   1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF,
           32'h0000_0100, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    access("ld_b_s", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FF00,
           32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_FF80);
    access("ld_b_u", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_FF00,
           32'h0000_0100, 4'b0000, 32'h0, 32'h0000_0080);
    access("st_h",   1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 32'hFFFF_FFFF,
           32'h0000_0020, 4'b1100, 32'hABCD_ABCD, 32'h0);
    access("st_b",   1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h0000_AA55, 32'h0,
           32'h0000_0040, 4'b0010, 32'h5555_5555, 32'h0);
    access("st_w",   1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,
           32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0);
    access("ld_h_s", 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_1234,
           32'h0000_0000, 4'b0000, 32'h0, 32'hFFFF_8001);
    access("ld_h_u", 1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0, 32'hAAAA_F00F,
           32'h0000_0010, 4'b0000, 32'h0, 32'h0000_F00F);
    access("ld_b_pos", 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_7F00,
           32'h0000_0000, 4'b0000, 32'h0, 32'h0000_007F);

    // Two stall cycles, ready in cycle 3: response in cycle 4.
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      check("stall.mem_valid", {31'b0, mem_valid}, 32'h1);
      check("stall.mem_addr", mem_addr, 32'h0000_0300);
      @(negedge clk);
    end
    check("stall.rsp_early", {31'b0, rsp_valid}, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    mem_ready = 1'b0;
    check("stall.rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check("stall.rsp_rdata", rsp_rdata, 32'h0BAD_CAFE);
    @(negedge clk);

    // Timeout: mem_valid for 4 cycles, error response in cycle 5.
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("to.mem_valid", {31'b0, mem_valid}, 32'h1);
      check("to.no_rsp", {31'b0, rsp_valid}, 32'h0);
      @(negedge clk);
    end
    check("to.rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check("to.rsp_err", {31'b0, rsp_err}, 32'h1);
    check("to.rsp_rdata", rsp_rdata, 32'h0);
    check("to.mem_valid_off", {31'b0, mem_valid}, 32'h0);
    @(negedge clk);
    check("to.ready_back", {31'b0, req_ready}, 32'h1);

    // Ready in the last allowed cycle wins over the timeout.
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("edge.mem_valid", {31'b0, mem_valid}, 32'h1);
    mem_ready = 1'b1;
    mem_rdata = 32'h1122_3344;
    @(negedge clk);
    mem_ready = 1'b0;
    check("edge.rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check("edge.rsp_err", {31'b0, rsp_err}, 32'h0);
    check("edge.rsp_rdata", rsp_rdata, 32'h1122_3344);
    @(negedge clk);

    // Illegal size: error one cycle after accept, no memory access.
    drive_req(1'b0, 2'b11, 1'b0, 32'h0000_0400, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("ill.mem_valid", {31'b0, mem_valid}, 32'h0);
    check("ill.rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check("ill.rsp_err", {31'b0, rsp_err}, 32'h1);
    @(negedge clk);
    check("ill.ready_back", {31'b0, req_ready}, 32'h1);

`ifdef LSU_MISALIGN_TRAP_EN
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("mis.mem_valid", {31'b0, mem_valid}, 32'h0);
    check("mis.rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check("mis.rsp_err", {31'b0, rsp_err}, 32'h1);
    check("mis.rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    drive_req(1'b0, 2'b01, 1'b1, 32'h0000_0103, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("mis_h.mem_valid", {31'b0, mem_valid}, 32'h0);
    check("mis_h.rsp_err", {31'b0, rsp_err}, 32'h1);
    @(negedge clk);
`else
    access("mis_w", 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h5566_7788,
           32'h0000_0100, 4'b0000, 32'h0, 32'h5566_7788);
    access("mis_h", 1'b0, 2'b01, 1'b1, 32'h0000_0103, 32'h0, 32'h5566_7788,
           32'h0000_0100, 4'b0000, 32'h0, 32'h0000_5566);
`endif

    // Reset during a stall drops mem_valid at once and discards the op.
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid.mem_valid_pre", {31'b0, mem_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.mem_valid", {31'b0, mem_valid}, 32'h0);
    check("rst_mid.busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid.no_rsp", {31'b0, rsp_valid}, 32'h0);
      check("rst_mid.req_ready", {31'b0, req_ready}, 32'h1);
    end
    access("post_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 32'h0F0F_0F0F,
           32'h0000_0600, 4'b0000, 32'h0, 32'h0F0F_0F0F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
